// File: rtl/mini_timer_pkg.sv
// rtl/mini_timer_pkg.sv - register map, CTRL layout and response record shared by the mini_timer files
package mini_timer_pkg;

    localparam logic [2:0] MTIME_LO    = 3'd0;
    localparam logic [2:0] MTIME_HI    = 3'd1;
    localparam logic [2:0] MTIMECMP_LO = 3'd2;
    localparam logic [2:0] MTIMECMP_HI = 3'd3;
    localparam logic [2:0] CTRL        = 3'd4;
    localparam logic [2:0] STATUS      = 3'd5;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_IE        = 1;
    localparam int CTRL_PRESC_LSB = 8;
    localparam int CTRL_PRESC_MSB = 15;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic        vld;
        logic [31:0] data;
    } resp_t;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mini_timer_resp_pipe.sv
// rtl/mini_timer_resp_pipe.sv - fixed-latency response shift register driving data_ok/rdata
module mini_timer_resp_pipe
    import mini_timer_pkg::*;
#(
    parameter int RESP_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  resp_t       resp_in,
    output logic        data_ok,
    output logic [31:0] rdata
);

    resp_t stage [RESP_LAT];

    always_ff @(posedge clk) begin
        if (rst_b) begin
            for (int i = 0; i < RESP_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= resp_in;
            for (int i = 1; i < RESP_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign data_ok = stage[RESP_LAT-1].vld;
    assign rdata   = stage[RESP_LAT-1].vld ? stage[RESP_LAT-1].data : '0;

endmodule

// File: rtl/mini_timer.sv
// rtl/mini_timer.sv - memory-mapped 64-bit machine timer; MINI_TIMER_PRESCALE_EN adds the CTRL prescaler
module mini_timer
    import mini_timer_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 32,
    parameter int RESP_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            timer_req,
    input  logic            timer_write,
    input  logic [DW/8-1:0] timer_wstrb,
    input  logic [AW-1:0]   timer_addr,
    input  logic [DW-1:0]   timer_wdata,
    output logic            timer_addr_ok,
    output logic            timer_data_ok,
    output logic [DW-1:0]   timer_rdata,
    output logic            timer_irq
);

    if (DW != 32) begin : g_dw_check
        $error("mini_timer: DW must be 32");
    end
    if (RESP_LAT < 1 || RESP_LAT > 4) begin : g_lat_check
        $error("mini_timer: RESP_LAT must be in 1..4");
    end

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        ctrl_en;
    logic        ctrl_ie;
    logic        tick;
    logic        accept;
    logic        wr_en;
    logic        wr_bytes;
    logic [2:0]  reg_idx;
    logic [31:0] ctrl_rd;
    logic [31:0] rd_data;
    logic [31:0] ctrl_merged;
    resp_t       resp_in;
    logic        unused_addr_bits;

    assign timer_addr_ok = !rst_b;
    assign accept        = timer_req && timer_addr_ok;
    assign wr_en         = accept && timer_write;
    assign wr_bytes      = wr_en && (timer_wstrb != '0);
    assign reg_idx       = timer_addr[4:2];
    assign unused_addr_bits = ^{timer_addr[AW-1:5], timer_addr[1:0]};

`ifdef MINI_TIMER_PRESCALE_EN
    logic [7:0] ctrl_presc;
    logic [7:0] presc_cnt;

    assign tick = ctrl_en && (presc_cnt == ctrl_presc);

    // Rewriting CTRL restarts the prescale period from zero.
    always_ff @(posedge clk) begin
        if (rst_b || !ctrl_en || (wr_en && reg_idx == CTRL)) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 8'd1;
        end
    end
`else
    assign tick = ctrl_en;
`endif

    always_comb begin
        ctrl_rd          = '0;
        ctrl_rd[CTRL_EN] = ctrl_en;
        ctrl_rd[CTRL_IE] = ctrl_ie;
`ifdef MINI_TIMER_PRESCALE_EN
        ctrl_rd[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = ctrl_presc;
`endif
    end

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            MTIME_LO:    rd_data = mtime[31:0];
            MTIME_HI:    rd_data = mtime[63:32];
            MTIMECMP_LO: rd_data = mtimecmp[31:0];
            MTIMECMP_HI: rd_data = mtimecmp[63:32];
            CTRL:        rd_data = ctrl_rd;
            STATUS:      rd_data = {31'd0, (mtime >= mtimecmp)};
            default:     rd_data = '0;
        endcase
    end

    assign ctrl_merged = byte_merge(ctrl_rd, timer_wdata, timer_wstrb);

    // A software write to either mtime half takes priority over that cycle's tick.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            mtime <= '0;
        end else if (wr_bytes && reg_idx == MTIME_LO) begin
            mtime[31:0] <= byte_merge(mtime[31:0], timer_wdata, timer_wstrb);
        end else if (wr_bytes && reg_idx == MTIME_HI) begin
            mtime[63:32] <= byte_merge(mtime[63:32], timer_wdata, timer_wstrb);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            mtimecmp <= MTIMECMP_RST;
        end else if (wr_en && reg_idx == MTIMECMP_LO) begin
            mtimecmp[31:0] <= byte_merge(mtimecmp[31:0], timer_wdata, timer_wstrb);
        end else if (wr_en && reg_idx == MTIMECMP_HI) begin
            mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], timer_wdata, timer_wstrb);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            ctrl_en <= 1'b0;
            ctrl_ie <= 1'b0;
        end else if (wr_en && reg_idx == CTRL) begin
            ctrl_en <= ctrl_merged[CTRL_EN];
            ctrl_ie <= ctrl_merged[CTRL_IE];
        end
    end

`ifdef MINI_TIMER_PRESCALE_EN
    always_ff @(posedge clk) begin
        if (rst_b) begin
            ctrl_presc <= '0;
        end else if (wr_en && reg_idx == CTRL) begin
            ctrl_presc <= ctrl_merged[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst_b) begin
            timer_irq <= 1'b0;
        end else begin
            timer_irq <= ctrl_ie && (mtime >= mtimecmp);
        end
    end

    // Read data is captured from the pre-update registers in the acceptance cycle.
    always_comb begin
        resp_in     = '0;
        resp_in.vld = accept;
        if (accept && !timer_write) begin
            resp_in.data = rd_data;
        end
    end

    mini_timer_resp_pipe #(
        .RESP_LAT (RESP_LAT)
    ) u_resp_pipe (
        .clk     (clk),
        .rst_b   (rst_b),
        .resp_in (resp_in),
        .data_ok (timer_data_ok),
        .rdata   (timer_rdata)
    );

endmodule

// File: tb/tb_mini_timer.sv
// tb/tb_mini_timer.sv - self-checking bench for mini_timer; honours MINI_TIMER_PRESCALE_EN
`timescale 1ns/1ps
module tb_mini_timer;

`ifdef MINI_TIMER_PRESCALE_EN
    localparam bit          PRESCALE  = 1'b1;
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF03;
`else
    localparam bit          PRESCALE  = 1'b0;
    localparam logic [31:0] CTRL_MASK = 32'h0000_0003;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b, req, write;
    logic [3:0]  wstrb;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        addr_ok, data_ok, irq;
    logic [31:0] rdata;

    logic        rst3, req3, write3;
    logic [3:0]  wstrb3;
    logic [15:0] addr3;
    logic [31:0] wdata3;
    logic        addr_ok3, data_ok3, irq3;
    logic [31:0] rdata3;

    mini_timer #(.AW(16), .DW(32), .RESP_LAT(1)) dut (
        .clk(clk), .rst_b(rst_b), .timer_req(req), .timer_write(write),
        .timer_wstrb(wstrb), .timer_addr(addr), .timer_wdata(wdata),
        .timer_addr_ok(addr_ok), .timer_data_ok(data_ok),
        .timer_rdata(rdata), .timer_irq(irq)
    );

    mini_timer #(.AW(16), .DW(32), .RESP_LAT(3)) dut3 (
        .clk(clk), .rst_b(rst3), .timer_req(req3), .timer_write(write3),
        .timer_wstrb(wstrb3), .timer_addr(addr3), .timer_wdata(wdata3),
        .timer_addr_ok(addr_ok3), .timer_data_ok(data_ok3),
        .timer_rdata(rdata3), .timer_irq(irq3)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: architectural state only.
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic [31:0] m_ctrl;
    int          m_since;
    bit          m_irq;
    logic [31:0] last_rdata;

    typedef struct {
        int          due;
        bit          is_read;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s at cycle %0d: got=%h expected=%h", name, cyc, got, want);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        case (a[4:2])
            3'd0:    return m_mtime[31:0];
            3'd1:    return m_mtime[63:32];
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return m_ctrl;
            3'd5:    return {31'd0, m_mtime >= m_cmp};
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input bit r, input bit rq, input bit wr, input logic [15:0] a,
                        input logic [3:0] s, input logic [31:0] d);
        bit          acc, wacc, tick, irq_n;
        int          idx, presc;
        logic [63:0] n_mtime;
        exp_t        e;
        rst_b = r; req = rq; write = wr; addr = a; wstrb = s; wdata = d;
        #1;
        check("addr_ok", 64'(addr_ok), 64'(!r));
        acc   = rq && !r;
        wacc  = acc && wr;
        idx   = int'(a[4:2]);
        irq_n = m_ctrl[1] && (m_mtime >= m_cmp);
        if (acc) q.push_back('{cyc + 1, !wr, m_read(a)});
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            m_mtime = 64'd0; m_cmp = '1; m_ctrl = 32'd0; m_since = 0; m_irq = 1'b0;
            q.delete();
        end else begin
            presc = int'(m_ctrl[15:8]);
            tick  = m_ctrl[0] && (!PRESCALE || (m_since % (presc + 1)) == presc);
            n_mtime = m_mtime;
            if (wacc && s != 4'd0 && idx == 0)      n_mtime[31:0]  = mrg(m_mtime[31:0], d, s);
            else if (wacc && s != 4'd0 && idx == 1) n_mtime[63:32] = mrg(m_mtime[63:32], d, s);
            else if (tick)                          n_mtime = m_mtime + 64'd1;
            m_since = (!m_ctrl[0] || (wacc && idx == 4)) ? 0 : m_since + 1;
            if (wacc && idx == 2) m_cmp[31:0]  = mrg(m_cmp[31:0], d, s);
            if (wacc && idx == 3) m_cmp[63:32] = mrg(m_cmp[63:32], d, s);
            if (wacc && idx == 4) m_ctrl = mrg(m_ctrl, d, s) & CTRL_MASK;
            m_mtime = n_mtime;
            m_irq   = irq_n;
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("data_ok", 64'(data_ok), 64'd1);
            if (e.is_read) check("rdata", 64'(rdata), 64'(e.data));
        end else begin
            check("data_ok_idle", 64'(data_ok), 64'd0);
            check("rdata_idle", 64'(rdata), 64'd0);
        end
        check("irq", 64'(irq), 64'(m_irq));
        last_rdata = rdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, a, 4'hF, d);
    endtask

    task automatic rd_reg(input logic [15:0] a);
        step(1'b0, 1'b1, 1'b0, a, 4'h0, 32'h0);
    endtask

    logic [31:0] exp3 [4];
    logic [15:0] adr3 [4];
    logic [31:0] rnd;

    initial begin
        rst_b = 1'b1; req = 1'b0; write = 1'b0; wstrb = '0; addr = '0; wdata = '0;
        rst3 = 1'b1; req3 = 1'b0; write3 = 1'b0; wstrb3 = '0; addr3 = '0; wdata3 = '0;
        m_mtime = '0; m_cmp = '1; m_ctrl = '0; m_since = 0; m_irq = 1'b0; last_rdata = '0;

        @(posedge clk); #1;
        step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
        check("reset_irq", 64'(irq), 64'd0);
        check("reset_data_ok", 64'(data_ok), 64'd0);

        tbl.push_back('{0, 16'h0010, 4'h0, 32'h0,          32'h0000_0000});
        tbl.push_back('{0, 16'h000C, 4'h0, 32'h0,          32'hFFFF_FFFF});
        tbl.push_back('{0, 16'h0014, 4'h0, 32'h0,          32'h0000_0000});
        tbl.push_back('{0, 16'h0000, 4'h0, 32'h0,          32'h0000_0000});
        tbl.push_back('{1, 16'h0008, 4'b0010, 32'hAABBCCDD, 32'h0});
        tbl.push_back('{0, 16'h0008, 4'h0, 32'h0,          32'hFFFF_CCFF});
        tbl.push_back('{1, 16'h0008, 4'b0000, 32'h0,        32'h0});
        tbl.push_back('{0, 16'h0008, 4'h0, 32'h0,          32'hFFFF_CCFF});
        tbl.push_back('{1, 16'h001C, 4'hF, 32'h1234_5678,  32'h0});
        tbl.push_back('{0, 16'h001C, 4'h0, 32'h0,          32'h0000_0000});
        tbl.push_back('{0, 16'h0018, 4'h0, 32'h0,          32'h0000_0000});
        tbl.push_back('{1, 16'h0010, 4'hF, 32'hFFFF_FFFF,  32'h0});
        tbl.push_back('{0, 16'h0010, 4'h0, 32'h0,          CTRL_MASK});
        tbl.push_back('{1, 16'h0010, 4'hF, 32'h0,          32'h0});
        tbl.push_back('{0, 16'hFF2B, 4'h0, 32'h0,          32'hFFFF_CCFF});
        foreach (tbl[i]) begin
            step(1'b0, 1'b1, tbl[i].wr, tbl[i].a, tbl[i].s, tbl[i].d);
            if (!tbl[i].wr) check($sformatf("tbl%0d", i), 64'(last_rdata), 64'(tbl[i].exp));
        end

        // 64-bit carry from LO into HI
        wr_reg(16'h0000, 32'hFFFF_FFFE);
        wr_reg(16'h0004, 32'h0);
        wr_reg(16'h0010, 32'h1);
        idle(3);
        rd_reg(16'h0004);
        check("carry_hi", 64'(last_rdata), 64'd1);
        rd_reg(16'h0000);
        check("carry_lo", 64'(last_rdata), 64'd2);

        // interrupt rise on compare match and fall after raising mtimecmp
        wr_reg(16'h0010, 32'h0);
        wr_reg(16'h000C, 32'h0);
        wr_reg(16'h0008, 32'd10);
        wr_reg(16'h0004, 32'h0);
        wr_reg(16'h0000, 32'h0);
        wr_reg(16'h0010, 32'h3);
        idle(10);
        check("irq_before_match", 64'(irq), 64'd0);
        idle(1);
        check("irq_after_match", 64'(irq), 64'd1);
        wr_reg(16'h0008, 32'd100);
        check("irq_same_cycle_as_cmp_write", 64'(irq), 64'd1);
        idle(1);
        check("irq_dropped", 64'(irq), 64'd0);

        // prescaler (or per-cycle tick when the prescaler is not built)
        wr_reg(16'h0010, 32'h0);
        wr_reg(16'h0004, 32'h0);
        wr_reg(16'h0000, 32'h0);
        wr_reg(16'h0010, 32'h0000_0401);
        idle(20);
        rd_reg(16'h0000);
        check("presc_mtime", 64'(last_rdata), PRESCALE ? 64'd4 : 64'd20);
        rd_reg(16'h0010);
        check("presc_ctrl", 64'(last_rdata), PRESCALE ? 64'h401 : 64'h1);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] d;
            rnd = $urandom;
            d   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 3) == 0 && rnd[4:2] == 3'd4) d[15:8] = 8'($urandom_range(0, 3));
            step($urandom_range(0, 99) == 0, rnd[16], rnd[17], rnd[15:0],
                 4'($urandom_range(1, 15)), d);
        end

        // RESP_LAT = 3: four back-to-back reads, then a reset mid-stream
        adr3[0] = 16'h000C; exp3[0] = 32'hFFFF_FFFF;
        adr3[1] = 16'h0010; exp3[1] = 32'h0;
        adr3[2] = 16'h0008; exp3[2] = 32'hFFFF_FFFF;
        adr3[3] = 16'h0014; exp3[3] = 32'h0;
        @(posedge clk); #1;
        rst3 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            req3  = (k < 4);
            addr3 = adr3[k % 4];
            @(posedge clk); #1;
            check("lat3_data_ok", 64'(data_ok3), 64'(k >= 2 && k <= 5));
            check("lat3_rdata", 64'(rdata3), (k >= 2 && k <= 5) ? 64'(exp3[(k + 2) % 4]) : 64'd0);
        end
        for (int k = 0; k < 10; k++) begin
            req3  = (k < 3);
            rst3  = (k == 3);
            addr3 = adr3[k % 4];
            #1;
            check("lat3_addr_ok", 64'(addr_ok3), 64'(k != 3));
            @(posedge clk); #1;
            check("lat3_rst_data_ok", 64'(data_ok3), 64'(k == 2));
            check("lat3_rst_rdata", 64'(rdata3), (k == 2) ? 64'hFFFF_FFFF : 64'd0);
        end
        check("lat3_irq", 64'(irq3), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
